s2a_controller: RTL and testbench

- Stream-to-AXI write engine for the OCM capture path.
- A stream source writes 32-bit words into a 32-entry ping-pong buffer (two 16-word halves); this block generates the buffer write address.
- Each time a half fills, the block issues one 16-beat AXI write burst that drains that half into a circular window in OCM.
- Single clock domain: stream side and AXI side both run on AXI_clk.

---
 rtl/s2a_controller_if.sv | 24 ++
 rtl/s2a_controller.sv | 126 ++++++++++++
 tb/tb_s2a_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/s2a_controller_if.sv
// AXI write-address/data/response channel bundle between the s2a write engine
// and the OCM interconnect.
interface s2a_controller_if;
  logic [31:0] AXI_waddr;
  logic [3:0]  AXI_awlen;
  logic        AXI_awvalid;
  logic        AXI_awready;
  logic        AXI_wvalid;
  logic        AXI_wready;
  logic        AXI_wlast;
  logic        AXI_bvalid;
  logic [1:0]  AXI_bresp;
  logic        AXI_bready;

  modport master (
    output AXI_waddr, AXI_awlen, AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready,
    input  AXI_awready, AXI_wready, AXI_bvalid, AXI_bresp
  );

  modport slave (
    input  AXI_waddr, AXI_awlen, AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready,
    output AXI_awready, AXI_wready, AXI_bvalid, AXI_bresp
  );
endinterface

// File: rtl/s2a_controller.sv
// Stream-to-AXI write engine: fills a 32-word ping-pong buffer from the stream
// and drains each completed 16-word half into a circular OCM window.
//
// state | meaning
// IDLE  | no burst in flight; launches a new or pending request
// ADDR  | AW channel valid, waiting for awready
// DATA  | streaming 16 W beats out of the drained half
// RESP  | waiting for the B response
module s2a_controller #(
  parameter logic [31:0] ocm_haddr = 32'hfffc0000,
  parameter int          ocm_width = 16
) (
  input  logic                AXI_clk,
  input  logic                rst,
  input  logic                sync,
  input  logic                Ien,
  output logic [4:0]          Iaddr,
  s2a_controller_if.master    axi,
  output logic [4:0]          s2a_addr,
  output logic                s2a_en,
  output logic [31:0]         s2a_cnt,
  output logic [1:0]          s2a_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [35:0] cnt;
  logic        req_half, pend_half, pending;
  logic [31:0] req_addr, pend_addr;
  logic        aw_valid, w_valid, w_last, b_ready;
  logic        blk_done, aw_hs, b_hs;
  logic [31:0] blk_off, new_addr;

  // Offset keeps only the block bits that fit the window, so it wraps there.
  assign blk_off  = {{(32 - ocm_width){1'b0}}, cnt[ocm_width-3:4], 6'b0};
  assign new_addr = ocm_haddr + blk_off;
  assign blk_done = Ien & ~sync & (cnt[3:0] == 4'hf);

  assign aw_hs  = aw_valid & axi.AXI_awready;
  assign s2a_en = w_valid & axi.AXI_wready;
  assign b_hs   = b_ready & axi.AXI_bvalid;

  assign Iaddr   = cnt[4:0];
  assign s2a_cnt = cnt[35:4];

  assign axi.AXI_waddr   = req_addr;
  assign axi.AXI_awlen   = 4'hf;
  assign axi.AXI_awvalid = aw_valid;
  assign axi.AXI_wvalid  = w_valid;
  assign axi.AXI_wlast   = w_last;
  assign axi.AXI_bready  = b_ready;

  always_ff @(posedge AXI_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pending || blk_done) state_nxt = ADDR;
      ADDR: if (aw_hs) state_nxt = DATA;
      DATA: if (s2a_en && s2a_addr[3:0] == 4'hf) state_nxt = RESP;
      RESP: if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    aw_valid = (state == ADDR);
    w_valid  = (state == DATA);
    w_last   = (state == DATA) && (s2a_addr[3:0] == 4'hf);
    b_ready  = (state == RESP);
    busy     = (state != IDLE);
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      cnt       <= '0;
      req_half  <= 1'b0;
      req_addr  <= '0;
      pend_half <= 1'b0;
      pend_addr <= '0;
      pending   <= 1'b0;
      s2a_addr  <= '0;
      s2a_err   <= '0;
    end else begin
      if (sync)     cnt <= '0;
      else if (Ien) cnt <= cnt + 36'd1;

      // A block finishing while IDLE drains a pending one is still on time;
      // it takes the freed pending slot without an overrun.
      if (state == IDLE) begin
        if (pending) begin
          req_half <= pend_half;
          req_addr <= pend_addr;
          pending  <= blk_done;
          if (blk_done) begin
            pend_half <= cnt[4];
            pend_addr <= new_addr;
          end
        end else if (blk_done) begin
          req_half <= cnt[4];
          req_addr <= new_addr;
        end
      end else if (blk_done) begin
        pend_half <= cnt[4];
        pend_addr <= new_addr;
        pending   <= 1'b1;
      end
      if (sync) pending <= 1'b0;

      if (sync) s2a_err <= 2'b00;
      if (blk_done && state != IDLE) s2a_err[0] <= 1'b1;
      if (b_hs && axi.AXI_bresp != 2'b00) s2a_err[1] <= 1'b1;

      if (aw_hs)
        s2a_addr <= {req_half, 4'h0};
      else if (s2a_en)
        s2a_addr[3:0] <= s2a_addr[3:0] + 4'd1;
    end
  end

endmodule

// File: tb/tb_s2a_controller.sv
// Scoreboard bench for s2a_controller: stimulus pushes expected bursts,
// a negedge monitor pops and checks AW/W/B traffic.
module tb_s2a_controller;

  typedef struct packed {
    logic [31:0] addr;
    logic        half;
  } exp_t;

  logic        AXI_clk = 1'b0;
  logic        rst, sync, Ien;
  logic [4:0]  Iaddr, s2a_addr;
  logic        s2a_en, busy;
  logic [31:0] s2a_cnt;
  logic [1:0]  s2a_err;

  s2a_controller_if axi ();

  s2a_controller dut (
    .AXI_clk  (AXI_clk),
    .rst      (rst),
    .sync     (sync),
    .Ien      (Ien),
    .Iaddr    (Iaddr),
    .axi      (axi),
    .s2a_addr (s2a_addr),
    .s2a_en   (s2a_en),
    .s2a_cnt  (s2a_cnt),
    .s2a_err  (s2a_err),
    .busy     (busy)
  );

  always #5 AXI_clk = ~AXI_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [31:0] aw_log[$];
  logic [35:0] mcnt = '0;

  logic        in_burst = 1'b0;
  logic        cur_half = 1'b0;
  int          beat = 0;
  logic        aw_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with Ien low.
  task automatic send(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      Ien = 1'b1;
      if (mcnt[3:0] == 4'hf) begin
        e.addr = 32'hfffc0000 + {16'h0, mcnt[13:4], 6'b0};
        e.half = mcnt[4];
        exp_q.push_back(e);
      end
      mcnt = mcnt + 36'd1;
      @(posedge AXI_clk); #1;
    end
    Ien = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !busy) && k < max_cycles) begin
      @(posedge AXI_clk); #1;
      k++;
    end
    if (k >= max_cycles) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, busy=%b queued=%0d", k, busy, exp_q.size());
    end
  endtask

  always @(negedge AXI_clk) begin
    exp_t e;
    if (!rst) begin
      if (aw_hold) chk("aw_hold", {31'd0, axi.AXI_awvalid}, 32'd1);
      aw_hold = axi.AXI_awvalid & ~axi.AXI_awready;

      if (axi.AXI_awvalid && axi.AXI_awready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_aw: got addr %h expected no burst", axi.AXI_waddr);
        end else begin
          e = exp_q.pop_front();
          chk("aw_addr", axi.AXI_waddr, e.addr);
          chk("aw_len", {28'd0, axi.AXI_awlen}, 32'hf);
          chk("aw_in_burst", {31'd0, in_burst}, 32'd0);
          cur_half = e.half;
          beat = 0;
          in_burst = 1'b1;
          aw_log.push_back(axi.AXI_waddr);
        end
      end

      if (axi.AXI_wvalid && axi.AXI_wready) begin
        chk("w_after_aw", {31'd0, in_burst}, 32'd1);
        chk("w_rdaddr", {27'd0, s2a_addr}, {27'd0, cur_half, 4'(beat)});
        chk("w_last", {31'd0, axi.AXI_wlast}, {31'd0, beat == 15});
        chk("w_en", {31'd0, s2a_en}, 32'd1);
        beat++;
      end

      if (axi.AXI_bvalid && axi.AXI_bready) begin
        chk("beat_count", beat, 32'd16);
        in_burst = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    sync = 1'b0;
    Ien = 1'b0;
    axi.AXI_awready = 1'b1;
    axi.AXI_wready  = 1'b1;
    axi.AXI_bvalid  = 1'b1;
    axi.AXI_bresp   = 2'b00;
    repeat (3) @(posedge AXI_clk);
    #1 rst = 1'b0;
    @(posedge AXI_clk); #1;

    chk("rst_iaddr", {27'd0, Iaddr}, 32'd0);
    chk("rst_cnt", s2a_cnt, 32'd0);
    chk("rst_err", {30'd0, s2a_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_waddr", axi.AXI_waddr, 32'd0);
    chk("rst_valids", {28'd0, axi.AXI_awvalid, axi.AXI_wvalid, axi.AXI_wlast, axi.AXI_bready}, 32'd0);
    chk("rst_rdaddr", {27'd0, s2a_addr}, 32'd0);

    // First block
    send(16);
    wait_idle(100);
    chk("b1_count", aw_log.size(), 32'd1);
    chk("b1_addr", aw_log[0], 32'hfffc0000);
    chk("b1_s2a_cnt", s2a_cnt, 32'd1);
    chk("b1_err", {30'd0, s2a_err}, 32'd0);
    chk("b1_iaddr", {27'd0, Iaddr}, 32'd16);

    // Second and third block
    send(16);
    wait_idle(100);
    send(16);
    wait_idle(100);
    chk("b3_count", aw_log.size(), 32'd3);
    chk("b2_addr", aw_log[1], 32'hfffc0040);
    chk("b3_addr", aw_log[2], 32'hfffc0080);
    chk("b3_s2a_cnt", s2a_cnt, 32'd3);

    // Fill the window, then wrap
    for (int b = 0; b < 1021; b++) begin
      send(16);
      wait_idle(100);
    end
    chk("b1024_s2a_cnt", s2a_cnt, 32'd1024);
    send(16);
    wait_idle(100);
    chk("wrap_count", aw_log.size(), 32'd1025);
    chk("b1024_addr", aw_log[1023], 32'hfffcffc0);
    chk("wrap_addr", aw_log[1024], 32'hfffc0000);
    chk("wrap_s2a_cnt", s2a_cnt, 32'd1025);
    chk("wrap_err", {30'd0, s2a_err}, 32'd0);

    // Overrun: block completes while the previous burst is stalled on W
    axi.AXI_wready = 1'b0;
    send(16);
    chk("ovr_busy", {31'd0, busy}, 32'd1);
    send(16);
    chk("ovr_err0", {31'd0, s2a_err[0]}, 32'd1);
    axi.AXI_awready = 1'b0;
    axi.AXI_wready  = 1'b1;
    repeat (40) @(posedge AXI_clk);
    #1;
    chk("ovr_awvalid", {31'd0, axi.AXI_awvalid}, 32'd1);
    chk("ovr_pend_count", aw_log.size(), 32'd1026);
    chk("ovr_pend_waddr", axi.AXI_waddr, 32'hfffc0080);
    axi.AXI_awready = 1'b1;
    wait_idle(100);
    chk("ovr_count", aw_log.size(), 32'd1027);

    // Bad B response
    axi.AXI_bresp = 2'b10;
    send(16);
    wait_idle(100);
    chk("bresp_err1", {31'd0, s2a_err[1]}, 32'd1);
    axi.AXI_bresp = 2'b00;

    // sync while a burst is in flight: stream state clears, burst finishes
    axi.AXI_wready = 1'b0;
    send(16);
    repeat (3) @(posedge AXI_clk);
    #1 sync = 1'b1;
    @(posedge AXI_clk); #1;
    sync = 1'b0;
    mcnt = '0;
    chk("sync_err", {30'd0, s2a_err}, 32'd0);
    chk("sync_iaddr", {27'd0, Iaddr}, 32'd0);
    chk("sync_cnt", s2a_cnt, 32'd0);
    chk("sync_busy", {31'd0, busy}, 32'd1);
    axi.AXI_wready = 1'b1;
    wait_idle(100);
    chk("sync_burst_count", aw_log.size(), 32'd1029);

    // sync and Ien together on the 16th word: no burst
    send(15);
    chk("pre_iaddr", {27'd0, Iaddr}, 32'd15);
    Ien = 1'b1;
    sync = 1'b1;
    @(posedge AXI_clk); #1;
    Ien = 1'b0;
    sync = 1'b0;
    mcnt = '0;
    repeat (5) @(posedge AXI_clk);
    #1;
    chk("same_busy", {31'd0, busy}, 32'd0);
    chk("same_cnt", s2a_cnt, 32'd0);
    chk("same_iaddr", {27'd0, Iaddr}, 32'd0);
    chk("same_count", aw_log.size(), 32'd1029);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
